// File: rtl/peak_muldiv_if.sv
// Issue/result bundle between the decoder, the RV32M execute unit and writeback.
// Flags are one-hot; BUSY stalls the pipe and READY marks a valid RESULT.
interface peak_muldiv_if;
    logic        START;
    logic        KILL;
    logic        INST_MUL;
    logic        INST_MULH;
    logic        INST_MULHSU;
    logic        INST_MULHU;
    logic        INST_DIV;
    logic        INST_DIVU;
    logic        INST_REM;
    logic        INST_REMU;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic        BUSY;
    logic        READY;
    logic [31:0] RESULT;

    modport master (
        output START, KILL,
        output INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU,
        output INST_DIV, INST_DIVU, INST_REM, INST_REMU,
        output RS1_DATA, RS2_DATA,
        input  BUSY, READY, RESULT
    );

    modport slave (
        input  START, KILL,
        input  INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU,
        input  INST_DIV, INST_DIVU, INST_REM, INST_REMU,
        input  RS1_DATA, RS2_DATA,
        output BUSY, READY, RESULT
    );
endinterface

// File: rtl/peak_muldiv.sv
// RV32M execute unit: 2-cycle multiply, 33-cycle radix-2 restoring divide.
// Results leave through registered BUSY/READY/RESULT only.
module peak_muldiv (
    input logic CLK,
    input logic RST,
    peak_muldiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        sa;
    logic        sb;
    logic        hi;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [32:0] rem;
    logic [4:0]  cnt;
    logic        negq;
    logic        negr;
    logic        divzero;
    logic        overflow;
    logic        is_rem;

    logic        is_mul;
    logic        is_div;
    logic        sdiv;
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    assign is_mul = bus.INST_MUL | bus.INST_MULH
                  | bus.INST_MULHSU | bus.INST_MULHU;
    assign is_div = bus.INST_DIV | bus.INST_DIVU
                  | bus.INST_REM | bus.INST_REMU;
    assign sdiv   = bus.INST_DIV | bus.INST_REM;
    assign a_abs  = (sdiv && bus.RS1_DATA[31]) ? -bus.RS1_DATA : bus.RS1_DATA;
    assign b_abs  = (sdiv && bus.RS2_DATA[31]) ? -bus.RS2_DATA : bus.RS2_DATA;

    // 66-bit signed product; only the low 64 bits are ever observable.
    logic [32:0]        a_ext;
    logic [32:0]        b_ext;
    logic signed [63:0] prod;
    logic [31:0]        mul_res;

    assign a_ext   = {sa & a_reg[31], a_reg};
    assign b_ext   = {sb & b_reg[31], b_reg};
    assign prod    = $signed({{31{a_ext[32]}}, a_ext})
                   * $signed({{31{b_ext[32]}}, b_ext});
    assign mul_res = hi ? prod[63:32] : prod[31:0];

    logic [33:0] shifted;
    logic [33:0] trial;
    logic        take;
    logic [32:0] next_rem;
    logic [31:0] next_dvd;
    logic [31:0] quo;
    logic [31:0] rmd;
    logic [31:0] div_res;

    // Quotient bits shift into the dividend register as it empties.
    assign shifted  = {rem, dvd[31]};
    assign trial    = shifted - {2'b00, dvs};
    assign take     = ~trial[33];
    assign next_rem = take ? trial[32:0] : shifted[32:0];
    assign next_dvd = {dvd[30:0], take};

    always_comb begin
        quo = negq ? -next_dvd : next_dvd;
        rmd = negr ? -next_rem[31:0] : next_rem[31:0];
        if (divzero) begin
            quo = 32'hFFFF_FFFF;
            rmd = a_reg;
        end else if (overflow) begin
            quo = 32'h8000_0000;
            rmd = 32'h0;
        end
        div_res = is_rem ? rmd : quo;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            sa         <= 1'b0;
            sb         <= 1'b0;
            hi         <= 1'b0;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            cnt        <= '0;
            negq       <= 1'b0;
            negr       <= 1'b0;
            divzero    <= 1'b0;
            overflow   <= 1'b0;
            is_rem     <= 1'b0;
            bus.BUSY   <= 1'b0;
            bus.READY  <= 1'b0;
            bus.RESULT <= '0;
        end else begin
            bus.READY <= 1'b0;
            if (bus.KILL) begin
                state    <= IDLE;
                bus.BUSY <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.START && is_mul) begin
                            a_reg    <= bus.RS1_DATA;
                            b_reg    <= bus.RS2_DATA;
                            sa       <= ~bus.INST_MULHU;
                            sb       <= bus.INST_MUL | bus.INST_MULH;
                            hi       <= ~bus.INST_MUL;
                            state    <= MUL;
                            bus.BUSY <= 1'b1;
                        end else if (bus.START && is_div) begin
                            a_reg    <= bus.RS1_DATA;
                            dvd      <= a_abs;
                            dvs      <= b_abs;
                            rem      <= '0;
                            cnt      <= '0;
                            negq     <= sdiv & (bus.RS1_DATA[31] ^ bus.RS2_DATA[31]);
                            negr     <= sdiv & bus.RS1_DATA[31];
                            divzero  <= (bus.RS2_DATA == 32'h0);
                            overflow <= sdiv
                                      && (bus.RS1_DATA == 32'h8000_0000)
                                      && (bus.RS2_DATA == 32'hFFFF_FFFF);
                            is_rem   <= bus.INST_REM | bus.INST_REMU;
                            state    <= DIV;
                            bus.BUSY <= 1'b1;
                        end
                    end
                    MUL: begin
                        bus.RESULT <= mul_res;
                        bus.READY  <= 1'b1;
                        state      <= DONE;
                    end
                    DIV: begin
                        dvd <= next_dvd;
                        rem <= next_rem;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            bus.RESULT <= div_res;
                            bus.READY  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        bus.BUSY <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
